// File: rtl/serial_arith_pkg.sv
// ---------------------------------------------------------------------------
// serial_arith_pkg
// Types and helpers shared by the bit-serial arithmetic blocks.
//   state_t   : control state of the serial adder (IDLE / RUN / DONE)
//   cnt_width : bit-position counter width able to hold 0..w
// ---------------------------------------------------------------------------
package serial_arith_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// ---------------------------------------------------------------------------
// serial_fa_cell
// Single full-adder cell: two half-add stages (XOR/AND) plus an OR for carry.
// Ports:
//   x, y : operand bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out
// ---------------------------------------------------------------------------
module serial_fa_cell (
   input  logic x,
   input  logic y,
   input  logic ci,
   output logic s,
   output logic co
);

   logic h1_s;
   logic h1_c;
   logic h2_c;

   assign h1_s = x ^ y;
   assign h1_c = x & y;
   assign s    = h1_s ^ ci;
   assign h2_c = h1_s & ci;
   assign co   = h1_c | h2_c;

endmodule

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
// Bit-serial LSB-first adder: one full-adder cell resolves one bit position
// per clock, with the carry held in a flop between steps. An addition takes
// WIDTH RUN cycles followed by a one-cycle DONE pulse. {cout,sum} = a+b+cin.
// Ports:
//   clk   : system clock, rising edge
//   rst   : synchronous active-high reset (aborts any operation)
//   start : begin an addition; ignored while busy
//   a, b  : operands, captured on accepted start
//   cin   : carry-in, captured on accepted start
//   busy  : high while bits are being processed (WIDTH cycles)
//   done  : one-cycle pulse, sum/cout freshly updated
//   sum   : registered result, held until next completion
//   cout  : registered carry-out, held until next completion
// ---------------------------------------------------------------------------
module serial_adder
   import serial_arith_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = cnt_width(WIDTH);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_nxt;
   logic             c;
   logic [CW-1:0]    cnt;
   logic             s_bit;
   logic             c_bit;
   logic             load;
   logic             last;

   serial_fa_cell u_fa (
      .x  (a_sh[0]),
      .y  (b_sh[0]),
      .ci (c),
      .s  (s_bit),
      .co (c_bit)
   );

   // A start is accepted from IDLE and also from DONE (back-to-back issue).
   assign load = (state != RUN) && start;
   assign last = (state == RUN) && (cnt == CW'(WIDTH - 1));

   // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at LSB.
   // Written as shift-then-overwrite so WIDTH=1 needs no special case.
   always_comb begin
      acc_nxt            = acc >> 1;
      acc_nxt[WIDTH-1]   = s_bit;
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last)  state_nxt = DONE;
         DONE:    state_nxt = start ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs decoded from state; busy and done are mutually exclusive
   always_comb begin
      busy = (state == RUN);
      done = (state == DONE);
   end

   // Operand shifters, carry flop, bit counter and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh <= '0;
         b_sh <= '0;
         acc  <= '0;
         c    <= 1'b0;
         cnt  <= '0;
         sum  <= '0;
         cout <= 1'b0;
      end else if (load) begin
         a_sh <= a;
         b_sh <= b;
         c    <= cin;
         cnt  <= '0;
         acc  <= '0;
      end else if (state == RUN) begin
         a_sh <= a_sh >> 1;
         b_sh <= b_sh >> 1;
         c    <= c_bit;
         acc  <= acc_nxt;
         cnt  <= cnt + 1'b1;
         if (last) begin
            sum  <= acc_nxt;
            cout <= c_bit;
         end
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
// Directed bench for serial_adder (WIDTH=8). A cycle-level reference model
// tracks what busy/done/sum/cout must be from the applied inputs, and a
// negedge process compares the DUT against it every cycle. Directed tasks
// also pin results and latencies to hand-computed literals.
// ---------------------------------------------------------------------------
module tb_serial_adder;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;

   int vectors;
   int errors;
   bit chk_en;

   serial_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: an accepted addition keeps the unit busy for W cycles,
   // then results appear with a one-cycle done. Arithmetic is plain a+b+cin.
   int         m_remain;
   bit         m_done;
   logic [W:0] m_pending;
   logic [W-1:0] m_sum;
   logic       m_cout;

   always @(posedge clk) begin
      if (rst) begin
         m_remain = 0;
         m_done   = 0;
         m_sum    = '0;
         m_cout   = 0;
      end else if (m_remain > 0) begin
         m_remain = m_remain - 1;
         if (m_remain == 0) begin
            {m_cout, m_sum} = m_pending;
            m_done = 1;
         end
      end else begin
         m_done = 0;
         if (start) begin
            m_pending = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            m_remain  = W;
         end
      end
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("busy", 64'(busy), 64'(m_remain > 0));
         check("done", 64'(done), 64'(m_done));
         check("sum",  64'(sum),  64'(m_sum));
         check("cout", 64'(cout), 64'(m_cout));
         if (busy && done) check("busy_and_done", 64'(1), 64'(0));
      end
   end

   // Wait for done at negedges, at most 20 cycles; returns cycles counted
   // from the start-accepting edge (the negedge right after it is 1).
   task automatic wait_done(input string nm, output int n);
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (done) begin
            n = i;
            break;
         end
      end
      if (n == 0) check({nm, "_timeout"}, 64'(0), 64'(1));
   endtask

   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic tc, input logic [W-1:0] es, input logic ec,
                         input string nm);
      int n;
      @(posedge clk); #1;
      a = ta; b = tb_v; cin = tc; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a = $urandom; b = $urandom; cin = $urandom;
      wait_done(nm, n);
      check({nm, "_latency"}, 64'(n), 64'(9));
      check({nm, "_sum"},     64'(sum),  64'(es));
      check({nm, "_cout"},    64'(cout), 64'(ec));
      check({nm, "_model"},   64'({m_cout, m_sum}), 64'({ec, es}));
   endtask

   initial begin
      int n;
      bit seen;
      vectors = 0;
      errors  = 0;
      chk_en  = 0;
      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk_en = 1;
      @(negedge clk);
      check("reset_busy", 64'(busy), 64'(0));
      check("reset_done", 64'(done), 64'(0));
      check("reset_sum",  64'(sum),  64'(0));
      check("reset_cout", 64'(cout), 64'(0));

      run_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, "add_0f_01");
      run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "add_ff_01");
      run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "add_ff_ff_c");
      run_op(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, "add_a5_5a_c");

      // Start during RUN must be ignored
      @(posedge clk); #1;
      a = 8'h55; b = 8'h2A; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1 a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      for (int i = 5; i <= 20; i++) begin
         @(negedge clk);
         if (done) begin n = i; break; end
      end
      check("ignore_latency", 64'(n), 64'(9));
      check("ignore_sum",  64'(sum),  64'(8'h7F));
      check("ignore_cout", 64'(cout), 64'(0));
      @(negedge clk);
      check("ignore_idle_after", 64'(busy), 64'(0));

      // Reset in mid-operation aborts with cleared outputs
      @(posedge clk); #1;
      a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_busy", 64'(busy), 64'(0));
      check("abort_sum",  64'(sum),  64'(0));
      check("abort_cout", 64'(cout), 64'(0));
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (done) seen = 1;
      end
      check("abort_no_done", 64'(seen), 64'(0));
      run_op(8'h03, 8'h04, 1'b0, 8'h07, 1'b0, "after_abort");

      // Back-to-back: start held high, new operands in the done cycle
      @(posedge clk); #1;
      a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
      @(posedge clk);
      wait_done("b2b_first", n);
      check("b2b_first_latency", 64'(n), 64'(9));
      check("b2b_first_sum", 64'(sum), 64'(8'h02));
      a = 8'h10; b = 8'h20; cin = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check("b2b_no_gap", 64'(busy), 64'(1));
      n = 0;
      for (int i = 2; i <= 20; i++) begin
         @(negedge clk);
         if (done) begin n = i; break; end
      end
      check("b2b_second_latency", 64'(n), 64'(9));
      check("b2b_second_sum",  64'(sum),  64'(8'h30));
      check("b2b_second_cout", 64'(cout), 64'(0));

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_en = 0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
